// File: rtl/bram_rw_port_flow.sv
// Single-port block RAM with byte-column writes, a valid/ready request channel and a
// credit-protected 2-entry read-response FIFO so that a stalled consumer never loses data.
module bram_rw_port_flow #(
  parameter int    RAM_WIDTH    = 18,
  parameter int    COL_WIDTH    = 9,
  parameter int    RAM_DEPTH    = 1024,
  parameter int    READ_LATENCY = 2,
  parameter string INIT_FILE    = "",
  localparam int   NUM_COL      = RAM_WIDTH / COL_WIDTH,
  localparam int   AW           = $clog2(RAM_DEPTH)
) (
  input  logic                 clka,
  input  logic                 rsta_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [NUM_COL-1:0]   req_be,
  input  logic [AW-1:0]        req_addr,
  input  logic [RAM_WIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [RAM_WIDTH-1:0] rsp_data
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_q_reg;
  logic [RAM_WIDTH-1:0] push_data;
  logic [RAM_WIDTH-1:0] fifo_reg [2];
  logic [NUM_COL-1:0]   col_we;
  logic [1:0]           used_reg;
  logic [1:0]           cnt_reg;
  logic                 wr_ptr_reg;
  logic                 rd_ptr_reg;
  logic                 rst_q_reg;
  logic                 pop;
  logic                 push;
  logic                 acc;
  logic                 acc_rd;
  logic                 acc_wr;

  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) mem[i] = '0;
  end

  // A popping response frees its credit in the same cycle, keeping the pipe full.
  assign pop       = rsp_valid & rsp_ready;
  assign req_ready = rst_q_reg & ((used_reg != 2'd2) | pop);
  assign acc       = req_valid & req_ready & rsta_n;
  assign acc_rd    = acc & ~req_we;
  assign acc_wr    = acc & req_we;

  generate
    for (genvar gi = 0; gi < NUM_COL; gi++) begin : g_col_we
      assign col_we[gi] = acc_wr & req_be[gi];
    end
  endgenerate

  always_ff @(posedge clka) begin
    for (int c = 0; c < NUM_COL; c++) begin
      if (col_we[c]) mem[req_addr][c*COL_WIDTH +: COL_WIDTH] <= req_wdata[c*COL_WIDTH +: COL_WIDTH];
    end
    if (acc_rd) ram_q_reg <= mem[req_addr];
  end

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      logic vld_reg;
      always_ff @(posedge clka) begin
        if (!rsta_n) vld_reg <= 1'b0;
        else         vld_reg <= acc_rd;
      end
      assign push      = vld_reg;
      assign push_data = ram_q_reg;
    end else begin : g_lat2
      logic [1:0]           vld_reg;
      logic [RAM_WIDTH-1:0] ram_q2_reg;
      always_ff @(posedge clka) begin
        if (!rsta_n) vld_reg <= 2'b00;
        else         vld_reg <= {vld_reg[0], acc_rd};
      end
      // Output register only loads when the array stage holds a live read.
      always_ff @(posedge clka) begin
        if (vld_reg[0]) ram_q2_reg <= ram_q_reg;
      end
      assign push      = vld_reg[1];
      assign push_data = ram_q2_reg;
    end
  endgenerate

  always_ff @(posedge clka) begin
    rst_q_reg <= rsta_n;
    if (!rsta_n) begin
      used_reg    <= 2'd0;
      cnt_reg     <= 2'd0;
      wr_ptr_reg  <= 1'b0;
      rd_ptr_reg  <= 1'b0;
      fifo_reg[0] <= '0;
      fifo_reg[1] <= '0;
    end else begin
      assert (!(push && (cnt_reg == 2'd2) && !pop));
      used_reg <= used_reg + 2'(acc_rd) - 2'(pop);
      cnt_reg  <= cnt_reg + 2'(push) - 2'(pop);
      if (push) begin
        fifo_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg           <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  assign rsp_valid = (cnt_reg != 2'd0);
  assign rsp_data  = fifo_reg[rd_ptr_reg];

endmodule
